alu_result_pipe: RTL and testbench
==================================

Name: alu_result_pipe

Overview:
- Parametrised successor to the ALU output selector. Selects one of NUM_OPS functional-unit results by opcode.
- Carries the result through a 2-stage valid/ready pipeline with full backpressure.
- Flags illegal opcodes and counts them.
- Sits between the ALU functional units (parity, popcount, rotr, rotl, and future ops) and the ALU writeback/consumer. All logic is rising-edge only.

Parameters:
- DATA_WIDTH, 512, width of each result word.
- NUM_OPS, 4, number of result channels. Legal opcodes are 0..NUM_OPS-1.
- OP_WIDTH, 3, opcode width. Must satisfy 2**OP_WIDTH >= NUM_OPS.
- CNT_WIDTH, 16, width of the illegal-opcode counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  opcode/results on the input are valid.
- in_ready  out  1  block accepts input this cycle.
- opcode  in  OP_WIDTH  operation select.
- op_results  in  NUM_OPS*DATA_WIDTH  packed results. Channel k is bits [k*DATA_WIDTH +: DATA_WIDTH]. Channel 0 is parity, 1 popcount, 2 rotr, 3 rotl.
- out_valid  out  1  alu_out holds a valid result.
- out_ready  in  1  consumer accepts the result.
- alu_out  out  DATA_WIDTH  selected result.
- out_opcode  out  OP_WIDTH  opcode belonging to alu_out.
- out_illegal  out  1  alu_out came from an illegal opcode.
- illegal_count  out  CNT_WIDTH  saturating count of illegal opcodes accepted.
- clear_count  in  1  synchronous clear of illegal_count.

Behaviour:
- Reset (async assert, released synchronously by the environment) clears:
  - s1_valid, s2_valid → out_valid = 0
  - all data/opcode registers, alu_out, out_opcode, out_illegal → 0
  - illegal_count → 0
- in_ready is 1 while rst is high and out of reset whenever stage 1 is free. Inputs presented while rst is high are ignored.
- Input handshake:
  - Transfer occurs when in_valid && in_ready.
  - Stage 1 captures opcode. It also captures the mux output: op_results channel [opcode], or all-zero if opcode >= NUM_OPS.
  - It captures illegal = (opcode >= NUM_OPS).
- Stage advance:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Stage 2 drives alu_out, out_opcode, out_illegal and out_valid directly from flops.
- Output handshake: transfer when out_valid && out_ready. While out_valid && !out_ready, alu_out, out_opcode and out_illegal are held stable. Stage 1 fills and then in_ready drops; no data is lost or duplicated.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+1. That is 2-cycle latency with no stall.
- Throughput: 1 result per cycle when out_ready is held high.
- Simultaneous events:
  - Output pop and s1→s2 move in the same cycle are allowed.
  - A new input is accepted in the same cycle that s1 moves to s2.
- Illegal counter:
  - Increments by 1 on each accepted input with opcode >= NUM_OPS.
  - Saturates at all-ones and does not wrap.
  - clear_count forces 0 on the next edge. Clear wins over a simultaneous increment.
- Illegal results still flow through the pipeline and are handshaken normally, with alu_out=0 and out_illegal=1.
- Reset asserted mid-stream flushes both stages immediately. Pending results are discarded and not replayed.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_PARITY=0, OP_POPCOUNT=1, OP_ROTR=2, OP_ROTL=3
  - default DATA_WIDTH and OP_WIDTH
- One sub-module, pipe_stage: a parametrised-width valid/ready register slice holding {illegal, opcode, data}. It is instantiated twice.
- The opcode decode mux and the illegal counter live in the top module.

Test Plan:
- Reset and idle: hold rst=1 for 3 cycles with in_valid=1 → out_valid=0, alu_out=0, illegal_count=0, in_ready=1. Release reset → first output appears 2 edges after the first accepted input.
- Per-channel select, 512-bit:
  - Stimulus: channel k = {16{32'hA5A5_0000 + k}}, opcodes 0,1,2,3 back to back, out_ready=1.
  - Required: alu_out matches channels 0..3 in order on 4 consecutive cycles; out_opcode=0..3; out_illegal=0.
- Backpressure:
  - Stimulus: stream opcodes 0,1,2,3, with out_ready=0 for 5 cycles starting when the first result is valid.
  - Required: alu_out holds channel 0; in_ready drops after stage 1 fills, accepting exactly 2 items. After out_ready=1, results arrive in order 0,1,2,3 with no loss or duplicates.
- Illegal opcode: opcodes 4, 7, 2 → outputs are {0, illegal=1}, {0, illegal=1}, then {channel 2, illegal=0}; illegal_count=2.
- Counter saturation and clear:
  - Stimulus: CNT_WIDTH=4, 20 illegal opcodes → illegal_count stops at 15.
  - Stimulus: clear_count=1 in the same cycle as an illegal accept → illegal_count=0.
- Reset mid-stream: assert rst asynchronously between edges while both stages are valid → out_valid falls immediately, before the next edge; no stale result is emitted after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcode map and default widths.
package alu_pkg;
  localparam int DEFAULT_DATA_WIDTH = 512;
  localparam int DEFAULT_OP_WIDTH   = 3;
  localparam int DEFAULT_NUM_OPS    = 4;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  localparam int OP_PARITY   = 0;
  localparam int OP_POPCOUNT = 1;
  localparam int OP_ROTR     = 2;
  localparam int OP_ROTL     = 3;
endpackage

// File: rtl/alu_result_pipe_stage.sv
// One valid/ready register slice. It accepts a new word when empty or when
// its own word leaves in the same cycle.
module pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign load        = in_valid_i && in_ready_o;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/alu_result_pipe.sv
// Opcode-selected ALU result carried through two valid/ready stages, with
// illegal-opcode flagging and a saturating illegal counter.
module alu_result_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_OPS    = DEFAULT_NUM_OPS,
  parameter int OP_WIDTH   = DEFAULT_OP_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OP_WIDTH-1:0]           opcode,
  input  logic [NUM_OPS*DATA_WIDTH-1:0] op_results,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         alu_out,
  output logic [OP_WIDTH-1:0]           out_opcode,
  output logic                          out_illegal,
  output logic [CNT_WIDTH-1:0]          illegal_count,
  input  logic                          clear_count
);
  localparam int SW = 1 + OP_WIDTH + DATA_WIDTH;

  logic [DATA_WIDTH-1:0] mux_data;
  logic                  mux_illegal;
  logic [SW-1:0]         s1_data, s2_data;
  logic                  s1_valid, s2_in_ready;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Opcodes with no matching channel fall through as zero data, flagged illegal.
  always_comb begin
    mux_data    = '0;
    mux_illegal = 1'b1;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (opcode == OP_WIDTH'(k)) begin
        mux_data    = op_results[k*DATA_WIDTH +: DATA_WIDTH];
        mux_illegal = 1'b0;
      end
    end
  end

  assign accept = in_valid && in_ready;

  pipe_stage #(.WIDTH(SW)) u_s1 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({mux_illegal, opcode, mux_data}),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_in_ready),
    .out_data_o  (s1_data)
  );

  pipe_stage #(.WIDTH(SW)) u_s2 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_in_ready),
    .in_data_i   (s1_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (s2_data)
  );

  assign {out_illegal, out_opcode, alu_out} = s2_data;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = '0;
    end else if (accept && mux_illegal && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_count = cnt_q;
endmodule

// File: tb/tb_alu_result_pipe.sv
// Directed bench for alu_result_pipe: select, latency, backpressure, illegal
// opcodes, counter saturation/clear and mid-stream reset.
module tb_alu_result_pipe;
  localparam int DW = 512;
  localparam int NO = 4;
  localparam int OW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [OW-1:0]    opcode;
  logic [NO*DW-1:0] op_results;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    alu_out;
  logic [OW-1:0]    out_opcode;
  logic             out_illegal;
  logic [15:0]      illegal_count;
  logic             clear_count;

  logic             s_in_ready, s_out_valid, s_out_illegal;
  logic [DW-1:0]    s_alu_out;
  logic [OW-1:0]    s_out_opcode;
  logic [3:0]       s_illegal_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n_acc;
  logic [OW-1:0] op_list[$];
  logic [DW-1:0] rx_data[$];
  logic [OW-1:0] rx_op[$];
  logic          rx_ill[$];
  logic [DW-1:0] ch_exp[4];

  always #5 clk = ~clk;

  alu_result_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op_results(op_results), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .out_opcode(out_opcode),
    .out_illegal(out_illegal), .illegal_count(illegal_count),
    .clear_count(clear_count)
  );

  alu_result_pipe #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .opcode(opcode), .op_results(op_results), .out_valid(s_out_valid),
    .out_ready(out_ready), .alu_out(s_alu_out), .out_opcode(s_out_opcode),
    .out_illegal(s_out_illegal), .illegal_count(s_illegal_count),
    .clear_count(clear_count)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (n_acc < op_list.size()) begin
      in_valid = 1'b1;
      opcode   = op_list[n_acc];
    end else begin
      in_valid = 1'b0;
      opcode   = '0;
    end
  endtask

  // Sample both handshakes mid-cycle, advance one edge, then re-drive inputs.
  task automatic cyc();
    logic acc, pop;
    @(negedge clk);
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop) begin
      rx_data.push_back(alu_out);
      rx_op.push_back(out_opcode);
      rx_ill.push_back(out_illegal);
    end
    @(posedge clk);
    #1;
    if (acc) n_acc++;
    drive();
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_op.delete();
    rx_ill.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    ch_exp[0] = {16{32'hA5A5_0000}};
    ch_exp[1] = {16{32'hA5A5_0001}};
    ch_exp[2] = {16{32'hA5A5_0002}};
    ch_exp[3] = {16{32'hA5A5_0003}};
    op_results  = {ch_exp[3], ch_exp[2], ch_exp[1], ch_exp[0]};
    rst         = 1'b1;
    in_valid    = 1'b1;
    opcode      = 3'd0;
    out_ready   = 1'b1;
    clear_count = 1'b0;
    n_acc       = 0;

    // Reset held with inputs offered: nothing enters the pipe.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_out", alu_out, '0);
    chk("rst_count", illegal_count, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Back-to-back legal opcodes, 2-cycle latency, one result per cycle.
    op_list = '{3'd0, 3'd1, 3'd2, 3'd3};
    n_acc = 0;
    drive();
    rst = 1'b0;
    cyc();
    chk("lat_not_yet", out_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("sel%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("sel%0d_data", k), alu_out, ch_exp[k]);
      chk($sformatf("sel%0d_op", k), out_opcode, OW'(k));
      chk($sformatf("sel%0d_ill", k), out_illegal, 1'b0);
    end
    cyc();
    chk("sel_drained", out_valid, 1'b0);

    // Backpressure: stall 5 cycles once the first result is visible.
    clear_rx();
    op_list = '{3'd0, 3'd1, 3'd2, 3'd3};
    n_acc = 0;
    drive();
    cyc();
    cyc();
    chk("bp_first_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("bp_hold%0d", i), alu_out, ch_exp[0]);
      chk($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
    end
    chk("bp_accepted", 32'(n_acc), 32'd2);
    out_ready = 1'b1;
    repeat (8) cyc();
    chk("bp_rx_count", 32'(rx_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      chk($sformatf("bp_rx%0d_data", i), rx_data[i], ch_exp[i]);
      chk($sformatf("bp_rx%0d_op", i), rx_op[i], OW'(i));
    end

    // Illegal opcodes flow as zero data with the flag set.
    clear_rx();
    op_list = '{3'd4, 3'd7, 3'd2};
    n_acc = 0;
    drive();
    repeat (6) cyc();
    chk("ill_rx_count", 32'(rx_data.size()), 32'd3);
    if (rx_data.size() == 3) begin
      chk("ill0_data", rx_data[0], '0);
      chk("ill0_flag", rx_ill[0], 1'b1);
      chk("ill0_op", rx_op[0], 3'd4);
      chk("ill1_data", rx_data[1], '0);
      chk("ill1_flag", rx_ill[1], 1'b1);
      chk("ill1_op", rx_op[1], 3'd7);
      chk("ill2_data", rx_data[2], ch_exp[2]);
      chk("ill2_flag", rx_ill[2], 1'b0);
    end
    chk("ill_count", illegal_count, 16'd2);

    // Plain clear, then 20 illegal accepts: 4-bit counter saturates at 15.
    op_list.delete();
    n_acc = 0;
    drive();
    clear_count = 1'b1;
    cyc();
    clear_count = 1'b0;
    chk("clr_count", illegal_count, 16'd0);
    chk("clr_count_sat", s_illegal_count, 4'd0);
    for (int i = 0; i < 20; i++) op_list.push_back(3'd5);
    n_acc = 0;
    drive();
    repeat (25) cyc();
    chk("sat_accepted", 32'(n_acc), 32'd20);
    chk("sat_count16", illegal_count, 16'd20);
    chk("sat_count4", s_illegal_count, 4'd15);

    // Clear wins over a simultaneous illegal accept.
    op_list = '{3'd6};
    n_acc = 0;
    drive();
    clear_count = 1'b1;
    cyc();
    clear_count = 1'b0;
    chk("clrwin_accepted", 32'(n_acc), 32'd1);
    chk("clrwin_count16", illegal_count, 16'd0);
    chk("clrwin_count4", s_illegal_count, 4'd0);
    repeat (3) cyc();
    chk("clrwin_after", illegal_count, 16'd0);

    // Mid-stream async reset with both stages full.
    clear_rx();
    op_list = '{3'd0, 3'd1, 3'd2, 3'd3};
    n_acc = 0;
    out_ready = 1'b0;
    drive();
    cyc();
    cyc();
    chk("mid_full_valid", out_valid, 1'b1);
    chk("mid_full_ready", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", alu_out, '0);
    chk("mid_rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    op_list.delete();
    n_acc = 0;
    out_ready = 1'b1;
    drive();
    repeat (4) cyc();
    chk("mid_no_stale", 32'(rx_data.size()), 32'd0);
    chk("mid_idle_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
